// File: rtl/seq_mult_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   state_t    : controller states (IDLE / BUSY / DONE)
//   cnt_width  : width of the iteration counter for an N-bit operand,
//                ceil(log2(N+1)) so the counter can represent 0..N.
// ----------------------------------------------------------------------------
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// seq_multiplier_if
// Operand/result handshake bundle for seq_multiplier.
//   in_valid / in_ready   : operand pair handshake (A, B, sgn)
//   out_valid / out_ready : product handshake (Z)
// Modports:
//   master : the producer/consumer around the multiplier
//   slave  : the multiplier itself
// ----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int N = 4
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] Z;

  modport master (
    output in_valid, A, B, sgn, out_ready,
    input  in_ready, out_valid, Z
  );

  modport slave (
    input  in_valid, A, B, sgn, out_ready,
    output in_ready, out_valid, Z
  );

endinterface

// File: rtl/mult_abs_neg.sv
// ----------------------------------------------------------------------------
// mult_abs_neg
// Combinational conditional two's-complement negate of a W-bit value.
// Used at N bits to take the magnitude of a signed operand (neg = sign bit)
// and at 2N bits to apply the product sign.
//   x   : input value
//   neg : 1 = output -x, 0 = output x
//   y   : result (W bits; -(-2^(W-1)) wraps to 2^(W-1), which is the correct
//         unsigned magnitude)
// ----------------------------------------------------------------------------
module mult_abs_neg #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Sequential N x N shift-add multiplier, unsigned or two's-complement.
// An operand pair is accepted in IDLE, N add/shift iterations run in BUSY
// (one per cycle) on operand magnitudes, and the sign-corrected 2N-bit
// product is held in DONE until the consumer takes it.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_multiplier_if.slave (in_valid/in_ready/A/B/sgn,
//           out_valid/out_ready/Z)
// ----------------------------------------------------------------------------
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_multiplier_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [2*N-1:0]  acc;    // running partial product
  logic [2*N-1:0]  mcand;  // multiplicand magnitude, shifted left each step
  logic [N-1:0]    mplr;   // multiplier magnitude, shifted right each step
  logic            neg;    // product sign captured at accept
  logic [2*N-1:0]  z_q;

  logic            accept;
  logic            last_iter;
  logic [N-1:0]    mag_a;
  logic [N-1:0]    mag_b;
  logic [2*N-1:0]  sum;
  logic [2*N-1:0]  prod;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_iter = (cnt == CW'(N - 1));

  // Operand magnitudes: negate only when signed mode and the sign bit is set.
  mult_abs_neg #(.W(N)) u_abs_a (
    .x   (bus.A),
    .neg (bus.sgn & bus.A[N-1]),
    .y   (mag_a)
  );

  mult_abs_neg #(.W(N)) u_abs_b (
    .x   (bus.B),
    .neg (bus.sgn & bus.B[N-1]),
    .y   (mag_b)
  );

  // Partial sum for this iteration; on the last iteration it is the final
  // magnitude, so the sign is applied to it directly and registered into Z.
  assign sum = mplr[0] ? (acc + mcand) : acc;

  mult_abs_neg #(.W(2*N)) u_neg_z (
    .x   (sum),
    .neg (neg),
    .y   (prod)
  );

  // State register and datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mplr  <= '0;
      neg   <= 1'b0;
      z_q   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= '0;
            mcand <= {{N{1'b0}}, mag_a};
            mplr  <= mag_b;
            neg   <= bus.sgn & (bus.A[N-1] ^ bus.B[N-1]);
            cnt   <= '0;
          end
        end
        BUSY: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + CW'(1);
          if (last_iter) z_q <= prod;
        end
        default: ;  // DONE: hold Z until handoff
      endcase
    end
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = BUSY;
      BUSY:    if (last_iter)     state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output decode: purely from registered state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.Z         = z_q;
  end

endmodule
